sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning the data width of each requester and of the SRAM port.
REQ-002 SHALL have parameter ADDRWIDTH, default 14, meaning the word address width.
REQ-003 SHALL have parameter FIXEDPRIO, default 0, where 0 selects round-robin arbitration and 1 gives requester 0 fixed priority.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 m0_req  input  1  requester 0 access request; held high until granted.
REQ-007 m0_we  input  1  requester 0 write enable (1 write, 0 read); qualified by m0_req.
REQ-008 m0_addr  input  ADDRWIDTH  requester 0 word address.
REQ-009 m0_wdata  input  DATAWIDTH  requester 0 write data.
REQ-010 m0_gnt  output  1  combinational grant; request accepted this cycle.
REQ-011 m0_rvalid  output  1  read data for requester 0 is valid on m0_rdata.
REQ-012 m0_rdata  output  DATAWIDTH  read data, equal to mem_q.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata SHALL have the same directions, widths and meanings for requester 1.
REQ-014 mem_addr  output  ADDRWIDTH  SRAM port address.
REQ-015 mem_we  output  1  SRAM port write enable.
REQ-016 mem_d  output  DATAWIDTH  SRAM port write data.
REQ-017 mem_q  input  DATAWIDTH  SRAM port read data, registered inside the SRAM (1-cycle latency, read-before-write).

Function
REQ-018 At most one of m0_gnt and m1_gnt SHALL be high in any cycle, and a grant SHALL only be given to a requester whose req is high.
REQ-019 If exactly one requester has req high and rst is low, that requester SHALL be granted in the same cycle.
REQ-020 With FIXEDPRIO=1, simultaneous requests SHALL grant m0.
REQ-021 With FIXEDPRIO=0, simultaneous requests SHALL grant the requester that was not granted most recently; the 1-bit last-grant register SHALL update only on cycles with a grant.
REQ-022 mem_addr, mem_d and mem_we SHALL equal the granted requester's addr, wdata and we, combinationally in the grant cycle.
REQ-023 With no grant, mem_we SHALL be 0, mem_addr SHALL be 0 and mem_d SHALL be 0.
REQ-024 A granted read (we=0) in cycle N SHALL assert that requester's rvalid for exactly cycle N+1, with rdata = mem_q carrying the SRAM content at addr as of cycle N.
REQ-025 A granted write SHALL never assert rvalid.
REQ-026 Back-to-back granted reads SHALL produce rvalid on consecutive cycles, giving a sustained throughput of 1 access per cycle with no bubbles.
REQ-027 The pending-read tracker SHALL be a registered valid bit plus an owner bit; rvalid for one requester SHALL never be asserted while the other requester's read is returning.
REQ-028 A read granted one cycle after a write to the same address SHALL return the newly written data.
REQ-029 m0_rdata and m1_rdata SHALL both be driven by mem_q at all times; only rvalid distinguishes the owner.
REQ-030 A request with req high and gnt low SHALL have no effect on the SRAM port.

Reset
REQ-031 While rst is high: m0_gnt=0, m1_gnt=0, mem_we=0, mem_addr=0 and mem_d=0, regardless of req.
REQ-032 On the cycle after rst is sampled high: m0_rvalid=0, m1_rvalid=0, pending-read valid=0 and last-grant=1, so that m0 wins the first contested round-robin cycle.
REQ-033 A read granted in the cycle before rst rises SHALL NOT produce rvalid after reset.

Verification
REQ-034 Single read: preload word 0x10 = 0xDEADBEEF; m0 reads 0x10 -> m0_gnt in cycle N; m0_rvalid=1 and m0_rdata=0xDEADBEEF in N+1; m1_rvalid stays 0.
REQ-035 Round robin (FIXEDPRIO=0): both requesters hold req reading for 6 cycles after reset -> grants alternate m0, m1, m0, m1, m0, m1; rvalid alternates one cycle later.
REQ-036 Fixed priority (FIXEDPRIO=1): both requesters hold req for 4 cycles -> m0_gnt=1 all 4 cycles and m1_gnt=0; m1 is granted in the first cycle m0_req drops.
REQ-037 Write then read: m1 writes 0x1234_5678 to 0x3FFF in cycle N; m0 reads 0x3FFF in N+1 -> m0_rvalid in N+2 with data 0x12345678; no rvalid in N+1.
REQ-038 Reset mid-read: m0 granted a read in cycle N and rst=1 in N+1 -> m0_rvalid=0 in N+1 and N+2, mem_we=0 throughout reset.
REQ-039 Idle: both req low -> mem_we=0, mem_addr=0, and no gnt or rvalid for 10 cycles.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Grants are combinational, so an uncontested or won request reaches the SRAM
// in the same cycle. Read data comes back one cycle later from the SRAM's
// registered output. A valid/owner pair tracks which requester owns that data.
module sram_port_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14,
  parameter int FIXEDPRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDRWIDTH-1:0] m0_addr,
  input  logic [DATAWIDTH-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DATAWIDTH-1:0] m0_rdata,

  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDRWIDTH-1:0] m1_addr,
  input  logic [DATAWIDTH-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DATAWIDTH-1:0] m1_rdata,

  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_d,
  input  logic [DATAWIDTH-1:0] mem_q
);

  // last_gnt_p0: 1 means m1 was granted most recently. It resets to 1 so that
  // m0 wins the first contested round-robin cycle.
  logic last_gnt_p0;
  // Outstanding read: valid plus owner (1 = m1). It lines up with mem_q.
  logic rd_vld_p1;
  logic rd_own_p1;

  // Grant decision. Contested cycles go to m0 under fixed priority. Under
  // round robin they go to the requester that was not granted last.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if ((FIXEDPRIO != 0) || last_gnt_p0) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // SRAM port mux. The port is held at zero when there is no grant.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_d    = '0;
    if (m0_gnt) begin
      mem_addr = m0_addr;
      mem_we   = m0_we;
      mem_d    = m0_wdata;
    end else if (m1_gnt) begin
      mem_addr = m1_addr;
      mem_we   = m1_we;
      mem_d    = m1_wdata;
    end
  end

  // ---- stage p0 -> p1: arbitration history and read tracking ----
  // This block records the round-robin history and the ownership of the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_p0 <= 1'b1;
      rd_vld_p1   <= 1'b0;
      rd_own_p1   <= 1'b0;
    end else begin
      if (m0_gnt || m1_gnt) begin
        last_gnt_p0 <= m1_gnt;
      end
      rd_vld_p1 <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
      rd_own_p1 <= m1_gnt;
    end
  end

  // rst also gates rvalid directly. A read granted just before reset asserts
  // therefore never shows up, not even in the first reset cycle.
  assign m0_rvalid = rd_vld_p1 && !rd_own_p1 && !rst;
  assign m1_rvalid = rd_vld_p1 &&  rd_own_p1 && !rst;
  assign m0_rdata  = mem_q;
  assign m1_rdata  = mem_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter. A round-robin instance is scoreboarded against
// a reference memory. A fixed-priority instance shares the same stimulus, and
// only its grants are checked. Each instance has its own behavioural SRAM.
module tb_sram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic [AW-1:0] fp_mem_addr;
  logic          fp_mem_we;
  logic [DW-1:0] fp_mem_d;
  logic [DW-1:0] fp_mem_q;

  sram_port_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .FIXEDPRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  sram_port_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .FIXEDPRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_d(fp_mem_d), .mem_q(fp_mem_q)
  );

  always #5 clk = ~clk;

  // Behavioural SRAMs: registered read, read-before-write.
  logic [DW-1:0] sram    [1 << AW];
  logic [DW-1:0] sram_fp [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  always @(posedge clk) begin
    mem_q <= sram[mem_addr];
    if (mem_we) sram[mem_addr] = mem_d;
    fp_mem_q <= sram_fp[fp_mem_addr];
    if (fp_mem_we) sram_fp[fp_mem_addr] = fp_mem_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit sb_push = 1'b1;

  typedef struct {
    int            due;
    bit            own;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // This monitor pops the scoreboard when a read is due and otherwise requires both rvalids low.
  logic          e0, e1;
  logic [DW-1:0] ed;
  exp_t          ent;
  always @(negedge clk) begin
    e0 = 1'b0;
    e1 = 1'b0;
    ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ent = sbq.pop_front();
      if (ent.own) e1 = 1'b1; else e0 = 1'b1;
      ed = ent.data;
    end
    chk("m0_rvalid", m0_rvalid, e0);
    chk("m1_rvalid", m1_rvalid, e1);
    if (e0) chk("m0_rdata", m0_rdata, ed);
    if (e1) chk("m1_rdata", m1_rdata, ed);
  end

  task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // This task checks the grants of both instances and the round-robin SRAM port.
  // It then updates the reference model and advances one clock.
  task automatic cycle_chk(input bit g0, input bit g1, input bit f0, input bit f1);
    logic [AW-1:0] ea;
    logic [DW-1:0] edat;
    logic          ew;
    @(negedge clk);
    chk("m0_gnt", m0_gnt, g0);
    chk("m1_gnt", m1_gnt, g1);
    chk("fp_m0_gnt", fp_m0_gnt, f0);
    chk("fp_m1_gnt", fp_m1_gnt, f1);
    ea = '0; edat = '0; ew = 1'b0;
    if (g0) begin
      ea = m0_addr; edat = m0_wdata; ew = m0_we;
    end else if (g1) begin
      ea = m1_addr; edat = m1_wdata; ew = m1_we;
    end
    chk("mem_addr", mem_addr, ea);
    chk("mem_d", mem_d, edat);
    chk("mem_we", mem_we, ew);
    if (g0 || g1) begin
      if (ew) ref_mem[ea] = edat;
      else if (sb_push) sbq.push_back('{cyc + 1, g1, ref_mem[ea]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = '0; sram_fp[i] = '0; ref_mem[i] = '0;
    end
    sram[14'h10] = 32'hDEADBEEF; sram_fp[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      sram[14'h20 + i]    = 32'hC0DE0000 + i * 32'h111;
      sram_fp[14'h20 + i] = 32'hC0DE0000 + i * 32'h111;
      ref_mem[14'h20 + i] = 32'hC0DE0000 + i * 32'h111;
    end

    // Reset with both requesters active: no grant, SRAM port idle.
    rst = 1'b1;
    drive(1, 1, 14'h55, 32'hAAAA5555, 1, 1, 14'h66, 32'h5555AAAA);
    @(posedge clk); #1;
    cycle_chk(0, 0, 0, 0);
    cycle_chk(0, 0, 0, 0);
    rst = 1'b0;

    // Round robin right after reset: m0 first, then alternating.
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 14'h20 + 2 * k, '0, 1, 0, 14'h21 + 2 * k, '0);
      cycle_chk(k % 2 == 0, k % 2 == 1, 1, 0);
    end

    // Idle for 10 cycles.
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    for (int k = 0; k < 10; k++) cycle_chk(0, 0, 0, 0);

    // Single read of the preloaded word.
    drive(1, 0, 14'h10, '0, 0, 0, '0, '0);
    cycle_chk(1, 0, 1, 0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle_chk(0, 0, 0, 0);

    // Contested for 4 cycles. Round robin resumes with m1, fixed priority always picks m0.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 14'h28 + k, '0, 1, 0, 14'h2C + k, '0);
      cycle_chk(k % 2 == 1, k % 2 == 0, 1, 0);
    end
    drive(0, 0, '0, '0, 1, 0, 14'h2C, '0);
    cycle_chk(0, 1, 0, 1);

    // m1 writes the top address, then m0 reads it back on the next cycle.
    drive(0, 0, '0, '0, 1, 1, 14'h3FFF, 32'h12345678);
    cycle_chk(0, 1, 0, 1);
    drive(1, 0, 14'h3FFF, '0, 0, 0, '0, '0);
    cycle_chk(1, 0, 1, 0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle_chk(0, 0, 0, 0);
    cycle_chk(0, 0, 0, 0);

    // Back-to-back reads: one access per cycle, rvalid on consecutive cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 14'h22 + k, '0, 0, 0, '0, '0);
      cycle_chk(1, 0, 1, 0);
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle_chk(0, 0, 0, 0);
    cycle_chk(0, 0, 0, 0);

    // A read is granted and reset follows one cycle later. Its data must never come back.
    drive(1, 0, 14'h10, '0, 0, 0, '0, '0);
    sb_push = 1'b0;
    cycle_chk(1, 0, 1, 0);
    sb_push = 1'b1;
    rst = 1'b1;
    drive(1, 1, 14'h77, 32'hFFFFFFFF, 1, 1, 14'h78, 32'hFFFFFFFF);
    cycle_chk(0, 0, 0, 0);
    cycle_chk(0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle_chk(0, 0, 0, 0);

    // After reset, the first contested round-robin cycle goes to m0 again.
    drive(1, 0, 14'h30, '0, 1, 0, 14'h31, '0);
    cycle_chk(1, 0, 1, 0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle_chk(0, 0, 0, 0);
    cycle_chk(0, 0, 0, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
